instr_fetch_buf: RTL and testbench
==================================

# instr_fetch_buf

Instruction prefetch stage sitting directly upstream of the single-cycle core. Generates sequential word addresses into the instruction memory, captures returned words with their PC into a small FIFO, and hands them to the core over a valid/ready handshake. A redirect from the core (taken jump/branch) flushes the FIFO, discards any in-flight word and restarts fetch at the target.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- mem_req  out  1  fetch request this cycle
- mem_addr  out  32  byte address of requested word (always word-aligned)
- mem_rdata  in  32  instruction word; valid exactly one cycle after mem_req, memory never stalls
- redirect  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
- instr_o  out  32  instruction to core
- instr_pc_o  out  32  PC of instr_o
- instr_valid_o  out  1  instr_o/instr_pc_o valid
- instr_ready_i  in  1  core accepts instruction

## Operation
- State: fetch PC fpc, in-flight flag inflight (1 bit) with its PC ifpc, FIFO of DEPTH {word, pc} entries, count 0..DEPTH.
- Issue: mem_req = !redirect && (count + inflight < DEPTH); mem_addr = fpc. On issue: fpc <= fpc + 4 (wraps mod 2^32), inflight <= 1, ifpc <= fpc; else inflight <= 0.
- Capture: when inflight=1 and no redirect, {mem_rdata, ifpc} is pushed into FIFO at end of that cycle.
- Pop: instr_valid_o && instr_ready_i removes head entry.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Credit check uses registered count only; a pop in the same cycle does not grant an extra request. Overflow is therefore impossible; push into a full FIFO is an assertion failure.
- Redirect (highest priority): FIFO emptied (count <= 0, pointers reset), inflight <= 0 (the word arriving next cycle, if any, is dropped), fpc <= {redirect_pc[31:2], 2'b00}, mem_req held 0 that cycle. A pop handshaking in the redirect cycle counts as consumed.
- instr_o/instr_pc_o undefined when instr_valid_o=0; bench checks them only when valid.

## Timing
- Reset (rst=0, async): fpc=RESET_PC, count=0, inflight=0, mem_req=0, instr_valid_o=0, instr_o=0, instr_pc_o=0. Outputs take reset values immediately, not at next edge.
- First cycle after rst deasserts: mem_req=1, mem_addr=RESET_PC.
- Request in cycle N → word in FIFO at edge ending N+1 → instr_valid_o in cycle N+2 (latency 2).
- Redirect in cycle R → mem_req=1 to target in R+1 → instr_valid_o in R+3.
- Steady state with instr_ready_i=1: one instruction per cycle once primed.
- Core stall: at most DEPTH words held; mem_req drops when count + inflight = DEPTH and resumes the cycle after a pop frees a slot.
- Reset mid-operation discards all state; no partial word is presented.

## Configuration
- IFB_BYPASS_EN defined: if FIFO is empty and inflight=1 (no redirect), instr_o=mem_rdata, instr_pc_o=ifpc, instr_valid_o=1 combinationally; if accepted the word is not pushed. Latency becomes 1 (request N → valid N+1); redirect-to-valid becomes R+2.
- Not defined: outputs driven only from FIFO head registers; no combinational path from mem_rdata to instr_o; latency 2.

## Test plan
- Reset: hold rst=0 3 cycles, release, ready=1 → mem_addr 0,4,8,…; instr_pc_o 0,4,8,… with matching words one per cycle, first valid 2 cycles after release (1 with IFB_BYPASS_EN).
- Backpressure: ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests (0..C) issued, count=4, mem_req=0; ready=1 → words 0..C popped in order, fetch resumes at 0x10, no loss/duplication.
- Redirect in flight: redirect=1, redirect_pc=0x103 while a request to 0x8 is in flight → word for 0x8 never presented, next mem_addr=0x100, next instr_pc_o=0x100.
- Redirect with pop: valid=ready=redirect=1 in the same cycle, FIFO holding 3 entries → head counted consumed, remaining 2 discarded, next valid pc=redirect target.
- Wrap: redirect_pc=0xFFFF_FFFC → instr_pc_o 0xFFFF_FFFC then 0x0000_0000.
- Reset mid-stream: drop rst while FIFO full → instr_valid_o=0, mem_req=0 immediately; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_buf.sv
// Instruction prefetch stage: sequential word fetch into a DEPTH-entry {word, pc} FIFO feeding the core.
// Define IFB_BYPASS_EN to forward a returning word straight to the core when the FIFO is empty.
module instr_fetch_buf #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic        instr_valid_o,
   input  logic        instr_ready_i
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [31:0]   fpc_q, fpc_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   ifpc_q, ifpc_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   word_q [DEPTH];
   logic [31:0]   pc_q [DEPTH];

   logic fifo_nonempty;
   logic issue;
   logic bypass_sel;
   logic handshake;
   logic push;
   logic pop_fifo;

   // Credit uses the registered count only, so a same-cycle pop never buys an extra request.
   assign fifo_nonempty = (count_q != '0);
   assign issue         = rst && !redirect && ((count_q + CW'(inflight_q)) < DEPTH_C);
   assign mem_req       = issue;
   assign mem_addr      = fpc_q;

`ifdef IFB_BYPASS_EN
   assign bypass_sel = !fifo_nonempty && inflight_q && !redirect;
`else
   assign bypass_sel = 1'b0;
`endif

   always_comb begin
      instr_valid_o = 1'b0;
      instr_o       = '0;
      instr_pc_o    = '0;
      if (fifo_nonempty) begin
         instr_valid_o = 1'b1;
         instr_o       = word_q[rd_ptr_q];
         instr_pc_o    = pc_q[rd_ptr_q];
      end else if (bypass_sel) begin
         instr_valid_o = 1'b1;
         instr_o       = mem_rdata;
         instr_pc_o    = ifpc_q;
      end
   end

   assign handshake = instr_valid_o && instr_ready_i;
   assign pop_fifo  = handshake && fifo_nonempty;
   assign push      = inflight_q && !redirect && !(bypass_sel && handshake);

   // A redirect wins over everything: flush the FIFO, drop the in-flight word, restart at the target.
   always_comb begin
      fpc_d      = fpc_q;
      inflight_d = inflight_q;
      ifpc_d     = ifpc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (redirect) begin
         fpc_d      = {redirect_pc[31:2], 2'b00};
         inflight_d = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         inflight_d = issue;
         if (issue) begin
            fpc_d  = fpc_q + 32'd4;
            ifpc_d = fpc_q;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop_fifo) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, pop_fifo})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fpc_q      <= RESET_PC;
         inflight_q <= 1'b0;
         ifpc_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fpc_q      <= fpc_d;
         inflight_q <= inflight_d;
         ifpc_q     <= ifpc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: the outputs are masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         word_q[wr_ptr_q] <= mem_rdata;
         pc_q[wr_ptr_q]   <= ifpc_q;
      end
   end

   fifoNoOverflow: assert property (@(posedge clk) disable iff (!rst)
      !(push && !pop_fifo && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_instr_fetch_buf.sv
// Self-checking bench for instr_fetch_buf: vector table for the reset/redirect stream, a scoreboard
// fed from the fetch requests, and hand-written backpressure, wrap, redirect-with-pop and reset cases.
module tb_instr_fetch_buf;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic        clk;
   logic        rst;
   logic        memReq;
   logic [31:0] memAddr;
   logic [31:0] memRdata;
   logic        redirect;
   logic [31:0] redirectPc;
   logic [31:0] instrO;
   logic [31:0] instrPcO;
   logic        instrValid;
   logic        instrReady;

   instr_fetch_buf #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_req       (memReq),
      .mem_addr      (memAddr),
      .mem_rdata     (memRdata),
      .redirect      (redirect),
      .redirect_pc   (redirectPc),
      .instr_o       (instrO),
      .instr_pc_o    (instrPcO),
      .instr_valid_o (instrValid),
      .instr_ready_i (instrReady)
   );

   typedef struct {
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic        expReq;
      logic [31:0] expAddr;
      logic        expValid;
      logic [31:0] expPc;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } sbEntry_t;

   vec_t        tv [10];
   sbEntry_t    sbQ [$];
   int          checks;
   int          errors;
   int          reqCount;
   int          popCount;
   logic [31:0] expFpc;
   logic        respValid;
   logic [31:0] respAddr;
   logic [31:0] seen [4];
   int          nSeen;
   int          firstK;

   function automatic logic [31:0] wordFor(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory answers exactly one cycle after each request and never stalls.
   always @(posedge clk) begin
      #1;
      memRdata = respValid ? wordFor(respAddr) : 32'hBAD0_BAD0;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // One cycle: drive at the falling edge, then check and update the scoreboard before the rising edge.
   task automatic applyStimulus(input logic rstV, input logic readyV, input logic redirV,
                                input logic [31:0] rpc);
      @(negedge clk);
      rst        = rstV;
      instrReady = readyV;
      redirect   = redirV;
      redirectPc = rpc;
      #1;
      if (!rst) begin
         checkOutput("rst_mem_req", memReq, 32'd0);
         checkOutput("rst_valid", instrValid, 32'd0);
         checkOutput("rst_instr", instrO, 32'd0);
         checkOutput("rst_instr_pc", instrPcO, 32'd0);
         sbQ.delete();
         expFpc    = RESET_PC;
         respValid = 1'b0;
      end else begin
         checkOutput("sb_mem_req", memReq, 32'(!redirect && (sbQ.size() < DEPTH)));
         if (instrValid && instrReady) begin
            popCount++;
            if (sbQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL sb_unexpected actual=pc 0x%08h required=no instruction", instrPcO);
            end else begin
               checkOutput("sb_pc", instrPcO, sbQ[0].pc);
               checkOutput("sb_word", instrO, sbQ[0].word);
               void'(sbQ.pop_front());
            end
         end
         respValid = memReq;
         respAddr  = memAddr;
         if (redirect) begin
            sbQ.delete();
            expFpc = {rpc[31:2], 2'b00};
         end else if (memReq) begin
            checkOutput("sb_mem_addr", memAddr, expFpc);
            sbQ.push_back('{pc: expFpc, word: wordFor(expFpc)});
            expFpc = expFpc + 32'd4;
            reqCount++;
         end
      end
   endtask

   task automatic collectPops(input int cycles, input logic readyV);
      nSeen  = 0;
      firstK = -1;
      for (int i = 0; i < 4; i++) seen[i] = 32'hDEAD_DEAD;
      for (int k = 0; k < cycles; k++) begin
         applyStimulus(1'b1, readyV, 1'b0, 32'h0);
         if (instrValid && instrReady) begin
            if (nSeen == 0) firstK = k;
            if (nSeen < 4) seen[nSeen] = instrPcO;
            nSeen++;
         end
      end
   endtask

   task automatic holdReset(input int cycles);
      for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      int popsBefore;
      checks     = 0;
      errors     = 0;
      reqCount   = 0;
      popCount   = 0;
      expFpc     = RESET_PC;
      respValid  = 1'b0;
      respAddr   = '0;
      rst        = 1'b0;
      instrReady = 1'b0;
      redirect   = 1'b0;
      redirectPc = '0;
      memRdata   = '0;

      // Stream from reset, redirect to 0x103 while the fetch of 0x8 is in flight.
      for (int i = 0; i < 10; i++) begin
         tv[i].ready   = 1'b1;
         tv[i].redir   = (i == 3);
         tv[i].rpc     = (i == 3) ? 32'h0000_0103 : 32'h0;
         tv[i].expReq  = (i != 3);
         tv[i].expAddr = (i < 3) ? 32'(4 * i) : 32'h100 + 32'(4 * (i - 4));
         if (i < 3) begin
            tv[i].expValid = (i >= LAT);
            tv[i].expPc    = 32'(4 * (i - LAT));
         end else if (i == 3) begin
            tv[i].expValid = (LAT == 2);
            tv[i].expPc    = 32'h4;
         end else begin
            tv[i].expValid = ((i - 4) >= LAT);
            tv[i].expPc    = 32'h100 + 32'(4 * (i - 4 - LAT));
         end
      end

      holdReset(3);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, tv[i].ready, tv[i].redir, tv[i].rpc);
         checkOutput($sformatf("tv%0d_req", i), memReq, 32'(tv[i].expReq));
         if (tv[i].expReq) checkOutput($sformatf("tv%0d_addr", i), memAddr, tv[i].expAddr);
         checkOutput($sformatf("tv%0d_valid", i), instrValid, 32'(tv[i].expValid));
         if (tv[i].expValid) checkOutput($sformatf("tv%0d_pc", i), instrPcO, tv[i].expPc);
      end

      // Address wrap past the top of memory.
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
      collectPops(8, 1'b1);
      checkOutput("wrap_lat", 32'(firstK), 32'(LAT));
      checkOutput("wrap_pc0", seen[0], 32'hFFFF_FFFC);
      checkOutput("wrap_pc1", seen[1], 32'h0000_0000);

      // Backpressure: only DEPTH requests go out while the core stalls.
      holdReset(3);
      reqCount = 0;
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("bp_reqs", 32'(reqCount), 32'd4);
      checkOutput("bp_req_low", memReq, 32'd0);
      checkOutput("bp_head_valid", instrValid, 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("bp_d0_pc", instrPcO, 32'h0);
      checkOutput("bp_d0_req", memReq, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("bp_d1_req", memReq, 32'd1);
      checkOutput("bp_resume_addr", memAddr, 32'h10);
      checkOutput("bp_d1_pc", instrPcO, 32'h4);
      collectPops(4, 1'b1);
      checkOutput("bp_pop2", seen[0], 32'h8);
      checkOutput("bp_pop3", seen[1], 32'hC);
      checkOutput("bp_pop4", seen[2], 32'h10);

      // Redirect while popping the head of a 3-entry FIFO.
      holdReset(3);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      popsBefore = popCount;
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0200);
      checkOutput("rp_head_valid", instrValid, 32'd1);
      checkOutput("rp_head_pc", instrPcO, 32'h0);
      checkOutput("rp_pops", 32'(popCount - popsBefore), 32'd1);
      collectPops(8, 1'b1);
      checkOutput("rp_lat", 32'(firstK), 32'(LAT));
      checkOutput("rp_first_pc", seen[0], 32'h200);
      checkOutput("rp_second_pc", seen[1], 32'h204);

      // Reset dropped while the FIFO is full must clear outputs before any clock edge.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("mid_full_valid", instrValid, 32'd1);
      checkOutput("mid_full_req", memReq, 32'd0);
      holdReset(3);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("mid_restart_req", memReq, 32'd1);
      checkOutput("mid_restart_addr", memAddr, RESET_PC);
      collectPops(6, 1'b1);
      checkOutput("mid_first_pc", seen[0], RESET_PC);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
